// File: rtl/fadd_arbiter_if.sv
// Requester-side channel of the shared fadd arbiter: op request with
// valid/ready handshake plus the returned result pulse.
interface fadd_arbiter_if;
  logic        valid;
  logic        ready;
  logic        sub;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        rsp_valid;
  logic [31:0] rsp_y;

  // Requester side drives the op and observes acceptance and result.
  modport master (
    output valid, sub, x1, x2,
    input  ready, rsp_valid, rsp_y
  );

  // Arbiter side accepts the op and returns the result.
  modport slave (
    input  valid, sub, x1, x2,
    output ready, rsp_valid, rsp_y
  );
endinterface

// File: rtl/fadd_arbiter.sv
// Shares one pipelined single-precision adder between two requesters.
// Round-robin issue, FSUB via x2 sign flip, and a tag pipeline that
// follows each op through the adder to route its result to its owner.
module fadd_arbiter #(
  parameter int unsigned LATENCY = 3
) (
  input  logic          sys_clk,
  input  logic          rst,
  fadd_arbiter_if.slave req0,
  fadd_arbiter_if.slave req1,
  output logic          fadd_valid,
  output logic [31:0]   fadd_x1,
  output logic [31:0]   fadd_x2,
  output logic          fadd_rstn,
  input  logic [31:0]   fadd_y,
  input  logic          fadd_out_valid,
  output logic          busy,
  output logic          err
);

  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_t;

  rr_t              rr_q;
  rr_t              rr_d;
  logic             gnt_any;
  logic             gnt_id;
  logic [LATENCY:0] tag_v;
  logic [LATENCY:0] tag_id;
  logic             tail_v;
  logic             tail_id;
  logic             mismatch;

  // Round-robin pointer register.
  always_ff @(posedge sys_clk) begin
    if (rst) rr_q <= RR_REQ0;
    else     rr_q <= rr_d;
  end

  // Grant selection and next pointer; the adder never stalls, so a grant is an accept.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    rr_d    = rr_q;
    if (!rst && (req0.valid || req1.valid)) begin
      gnt_any = 1'b1;
      gnt_id  = (req0.valid && req1.valid) ? (rr_q == RR_REQ1) : req1.valid;
      rr_d    = gnt_id ? RR_REQ0 : RR_REQ1;
    end
  end

  assign req0.ready = gnt_any & ~gnt_id;
  assign req1.ready = gnt_any &  gnt_id;

  // Issue valid register.
  always_ff @(posedge sys_clk) begin
    if (rst) fadd_valid <= 1'b0;
    else     fadd_valid <= gnt_any;
  end

  // Issue operand registers; subtraction folds into the x2 sign.
  always_ff @(posedge sys_clk) begin
    if (gnt_any) begin
      if (gnt_id) begin
        fadd_x1 <= req1.x1;
        fadd_x2 <= {req1.x2[31] ^ req1.sub, req1.x2[30:0]};
      end else begin
        fadd_x1 <= req0.x1;
        fadd_x2 <= {req0.x2[31] ^ req0.sub, req0.x2[30:0]};
      end
    end
  end

  // Tag pipeline: entry 0 loads with the issue register, tail lines up with fadd_out_valid.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[LATENCY-1:0], gnt_any};
      tag_id <= {tag_id[LATENCY-1:0], gnt_id};
    end
  end

  assign tail_v   = tag_v[LATENCY];
  assign tail_id  = tag_id[LATENCY];
  assign mismatch = fadd_out_valid ^ tail_v;

  // Both operands of the AND must be high, so a mismatch cycle never pulses a response.
  assign req0.rsp_valid = fadd_out_valid & tail_v & ~tail_id;
  assign req1.rsp_valid = fadd_out_valid & tail_v &  tail_id;
  assign req0.rsp_y     = fadd_y;
  assign req1.rsp_y     = fadd_y;

  // Sticky error flag on any adder/tag valid disagreement.
  always_ff @(posedge sys_clk) begin
    if (rst)           err <= 1'b0;
    else if (mismatch) err <= 1'b1;
  end

  assign busy      = fadd_valid | (|tag_v);
  assign fadd_rstn = ~rst;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: a behavioural adder stands in for fadd, a queue
// model predicts grants, responses, busy and err, and a negedge process
// compares the DUT against it every cycle.
module tb_fadd_arbiter;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  fadd_arbiter_if r0 ();
  fadd_arbiter_if r1 ();

  logic        fadd_valid;
  logic [31:0] fadd_x1;
  logic [31:0] fadd_x2;
  logic        fadd_rstn;
  logic [31:0] fadd_y;
  logic        fadd_out_valid;
  logic        busy;
  logic        err;
  logic        inj = 1'b0;

  int checks = 0;
  int errors = 0;

  fadd_arbiter #(.LATENCY(3)) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .req0           (r0),
    .req1           (r1),
    .fadd_valid     (fadd_valid),
    .fadd_x1        (fadd_x1),
    .fadd_x2        (fadd_x2),
    .fadd_rstn      (fadd_rstn),
    .fadd_y         (fadd_y),
    .fadd_out_valid (fadd_out_valid),
    .busy           (busy),
    .err            (err)
  );

  function automatic real sp2real(logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m * 0.5;
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real2sp(real r);
    logic [63:0] d;
    int          e;
    logic [7:0]  e8;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    e  = int'(d[62:52]) - 1023 + 127;
    e8 = e[7:0];
    return {d[63], e8, d[51:29]};
  endfunction

  function automatic logic [31:0] spadd(logic [31:0] a, logic [31:0] b, logic sub);
    return real2sp(sub ? sp2real(a) - sp2real(b) : sp2real(a) + sp2real(b));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Stand-in adder: three-stage pipeline, valid chain cleared by fadd_rstn.
  logic        fv [3];
  logic [31:0] fy [3];
  always @(posedge sys_clk) begin
    if (!fadd_rstn) begin
      fv[0] <= 1'b0; fv[1] <= 1'b0; fv[2] <= 1'b0;
    end else begin
      fv[0] <= fadd_valid; fv[1] <= fv[0]; fv[2] <= fv[1];
    end
    fy[0] <= real2sp(sp2real(fadd_x1) + sp2real(fadd_x2));
    fy[1] <= fy[0];
    fy[2] <= fy[1];
  end
  assign fadd_out_valid = fv[2] | inj;
  assign fadd_y         = fy[2];

  // Reference model: accepted ops wait in a queue until their due cycle.
  typedef struct {
    int          due;
    bit          id;
    logic [31:0] y;
  } op_t;

  op_t q[$];
  int  cyc   = 0;
  bit  rr    = 1'b0;
  bit  err_m = 1'b0;

  function automatic bit m_any();
    return !rst && (r0.valid || r1.valid);
  endfunction

  function automatic bit m_id();
    return (r0.valid && r1.valid) ? rr : r1.valid;
  endfunction

  always @(posedge sys_clk) begin
    if (rst) begin
      q.delete();
      rr    = 1'b0;
      err_m = 1'b0;
    end else begin
      op_t o;
      if (inj) err_m = 1'b1;
      if (m_any()) begin
        o.due = cyc + 4;
        o.id  = m_id();
        o.y   = o.id ? spadd(r1.x1, r1.x2, r1.sub) : spadd(r0.x1, r0.x2, r0.sub);
        q.push_back(o);
        rr = !o.id;
      end
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge sys_clk) begin
    bit          found;
    bit          fid;
    logic [31:0] fyv;
    bit          fv_exp;
    found  = 1'b0;
    fid    = 1'b0;
    fyv    = '0;
    fv_exp = 1'b0;
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        found = 1'b1; fid = q[i].id; fyv = q[i].y;
      end
      if (q[i].due == cyc + 3) fv_exp = 1'b1;
    end
    if (inj) found = 1'b0;
    chk("ready0", r0.ready, m_any() && !m_id());
    chk("ready1", r1.ready, m_any() &&  m_id());
    chk("rsp0_valid", r0.rsp_valid, found && !fid);
    chk("rsp1_valid", r1.rsp_valid, found &&  fid);
    if (found && !fid) chk("rsp0_y", r0.rsp_y, fyv);
    if (found &&  fid) chk("rsp1_y", r1.rsp_y, fyv);
    chk("busy", busy, q.size() > 0);
    chk("fadd_valid", fadd_valid, fv_exp);
    chk("err", err, err_m);
    chk("fadd_rstn", fadd_rstn, !rst);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set0(bit v, bit s, logic [31:0] a, logic [31:0] b);
    r0.valid = v; r0.sub = s; r0.x1 = a; r0.x2 = b;
  endtask

  task automatic set1(bit v, bit s, logic [31:0] a, logic [31:0] b);
    r1.valid = v; r1.sub = s; r1.x1 = a; r1.x2 = b;
  endtask

  task automatic idle();
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_sp();
    int k;
    k = int'($urandom_range(2000)) - 1000;
    return real2sp(real'(k));
  endfunction

  initial begin
    int cnt;
    // Reset with both requesters pending: nothing may be granted.
    set0(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
    set1(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
    repeat (3) tick();
    rst = 1'b0;
    idle();
    @(negedge sys_clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("model_1p2", spadd(32'h3F800000, 32'h40000000, 1'b0), 32'h40400000);
    chk("model_3m1", spadd(32'h40400000, 32'h3F800000, 1'b1), 32'h40000000);

    // T1 single add on requester 0.
    tick();
    set0(1'b1, 1'b0, 32'h3F800000, 32'h40000000);
    tick();
    idle();
    repeat (3) tick();
    @(negedge sys_clk);
    chk("t1_rsp0_valid", r0.rsp_valid, 1'b1);
    chk("t1_rsp0_y", r0.rsp_y, 32'h40400000);
    chk("t1_rsp1_valid", r1.rsp_valid, 1'b0);

    // T2 subtract on requester 1.
    tick();
    set1(1'b1, 1'b1, 32'h40400000, 32'h3F800000);
    tick();
    idle();
    @(negedge sys_clk);
    chk("t2_fadd_x2", fadd_x2, 32'hBF800000);
    chk("t2_fadd_valid", fadd_valid, 1'b1);
    repeat (3) tick();
    @(negedge sys_clk);
    chk("t2_rsp1_valid", r1.rsp_valid, 1'b1);
    chk("t2_rsp1_y", r1.rsp_y, 32'h40000000);

    // T3 contention straight out of reset.
    do_reset(1);
    set0(1'b1, 1'b0, 32'h40A00000, 32'h3F800000);
    set1(1'b1, 1'b1, 32'h41200000, 32'h40000000);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("t3_ready0", r0.ready, (i % 2) == 0);
      chk("t3_ready1", r1.ready, (i % 2) == 1);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("t3_rsp0", r0.rsp_valid, (i % 2) == 0);
      chk("t3_rsp1", r1.rsp_valid, (i % 2) == 1);
      if ((i % 2) == 0) chk("t3_y0", r0.rsp_y, 32'h40C00000);
      else              chk("t3_y1", r1.rsp_y, 32'h41000000);
      tick();
    end

    // T4 streaming on requester 0.
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set0(1'b1, i[0], real2sp(real'(i + 1)), real2sp(real'(3 * i)));
      @(negedge sys_clk);
      chk("t4_ready0", r0.ready, 1'b1);
      if (i > 0) chk("t4_busy", busy, 1'b1);
      if (r0.rsp_valid === 1'b1) cnt++;
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (i < 4) chk("t4_busy_tail", busy, 1'b1);
      if (r0.rsp_valid === 1'b1) cnt++;
      tick();
    end
    chk("t4_rsp_count", cnt, 10);

    // T5 reset while ops are in flight.
    for (int i = 0; i < 3; i++) begin
      set0(1'b1, 1'b0, rnd_sp(), rnd_sp());
      set1(1'b1, 1'b1, rnd_sp(), rnd_sp());
      tick();
    end
    idle();
    tick();
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk("t5_rsp0", r0.rsp_valid, 1'b0);
      chk("t5_rsp1", r1.rsp_valid, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_err", err, 1'b0);
      tick();
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      set0($urandom_range(99) < 60, $urandom_range(1) == 1, rnd_sp(), rnd_sp());
      set1($urandom_range(99) < 60, $urandom_range(1) == 1, rnd_sp(), rnd_sp());
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0;
    idle();

    // T6 spurious adder valid with an empty tag pipeline.
    repeat (6) tick();
    inj = 1'b1;
    @(negedge sys_clk);
    chk("t6_rsp0", r0.rsp_valid, 1'b0);
    chk("t6_rsp1", r1.rsp_valid, 1'b0);
    tick();
    inj = 1'b0;
    @(negedge sys_clk);
    chk("t6_err_set", err, 1'b1);
    repeat (5) tick();
    @(negedge sys_clk);
    chk("t6_err_sticky", err, 1'b1);
    do_reset(1);
    @(negedge sys_clk);
    chk("t6_err_clear", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
